ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Parametrised execute stage for the ARM pipeline, merged with its own EX/MEM pipeline register.
- Performs operand forwarding, shifter-operand generation, ALU with NZCV flags, and branch-target computation.
- Adds a multi-cycle multiply unit that stalls upstream through a handshake.
- Sits between the ID/EX register and the MEM stage. Supersedes the fixed-width execute wrapper and adds flush, valid tracking and stall support.

Parameters:
- REG_WIDTH, 32, datapath/register width; must be >=16 and even.
- ADDR_WIDTH, 32, PC/branch address width.
- REG_ADDR_WIDTH, 4, destination register index width.
- MUL_LATENCY, 3, total cycles a MUL occupies EX (1..15).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  ID/EX holds a real instruction
- pc_in  in  ADDR_WIDTH  PC of the instruction (already +4)
- wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in  in  1 each  control bits
- immd  in  1  shifter operand is an immediate
- exe_cmd  in  4  ALU command
- val_rn, val_rm_in  in  REG_WIDTH  register-file operands
- dest_in  in  REG_ADDR_WIDTH  destination register
- signed_immd_24  in  24  branch offset
- shift_operand  in  12  ARM shifter-operand field
- status_reg_in  in  4  current NZCV
- fwd_sel_src1, fwd_sel_src2  in  2 each  0 = register, 1 = MEM value, 2 = WB value, 3 = register
- mem_fwd_value, wb_fwd_value  in  REG_WIDTH  forwarded results
- freeze  in  1  hold EX/MEM register (MEM-side stall)
- flush  in  1  squash the current EX instruction
- stall_out  out  1  EX cannot accept a new instruction; upstream holds
- valid_out, wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls
- alu_res_out, val_rm_out  out  REG_WIDTH  registered result / store data
- dest_out  out  REG_ADDR_WIDTH  registered destination
- status_w_en_out  out  1  combinational: write NZCV this cycle
- status_out  out  4  combinational NZCV
- branch_taken_out  out  1  combinational: valid_in & b_in & ~stall_out
- branch_address_out  out  ADDR_WIDTH  pc_in + (sign-extended signed_immd_24 << 2), modulo 2^ADDR_WIDTH
- wb_en_hazard_out, dest_hazard_out  out  1 / REG_ADDR_WIDTH  pass-through of wb_en_in / dest_in for hazard detection

Behaviour:
- Forwarding: src1 is val_rn muxed by fwd_sel_src1. Forwarded Rm value feeds both the shifter and val_rm_out.
- val2 generation:
  - mem_r_en_in | mem_w_en_in: zero-extended shift_operand[11:0].
  - immd: imm8 = shift_operand[7:0], rotated right by 2*shift_operand[11:8], zero-extended in REG_WIDTH.
  - Otherwise: forwarded Rm shifted by shift_operand[11:7], type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). A shift amount of 0 means no shift.
- exe_cmd encoding:
  - 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL.
  - Other codes give result 0 and leave flags unchanged.
- Flags: N = result MSB, Z = result==0. C/V come only from ADD/ADC/SUB/SBC. SUB carry = NOT borrow. Logic ops and MOV keep C/V from status_reg_in.
- Multiply FSM:
  - States IDLE, BUSY.
  - IDLE -> BUSY when valid_in & cmd==MUL & ~freeze & ~flush & MUL_LATENCY>1; loads cnt = MUL_LATENCY-2.
  - BUSY: cnt decrements each unfrozen cycle. When cnt==0 and ~freeze, go to IDLE; the result is written that cycle.
  - stall_out = (IDLE & valid_in & MUL & MUL_LATENCY>1) | (BUSY & cnt!=0).
  - Product = low REG_WIDTH bits of src1*val2, computed once at issue and held.
  - MUL_LATENCY==1: single cycle, never stalls.
- EX/MEM register priority: rst > flush > freeze > stall_out > load.
  - rst and flush: all registered outputs 0; FSM to IDLE with cnt 0.
  - freeze: all registered outputs hold; FSM holds.
  - stall_out: load a bubble (valid_out = wb_en_out = mem_*_out = 0; data and dest hold).
  - load: capture current values; every enable is ANDed with valid_in.
- status_w_en_out = valid_in & s_in & ~stall_out & ~freeze & ~flush. Asserted exactly once per instruction, including MUL.
- Reset values: all registered outputs 0, state IDLE.

Optional Feature:
- Macro EX_MUL_EN.
- Defined: MUL decoding and FSM present as above.
- Undefined: cmd 1010 treated as an unknown op (result 0, flags unchanged), stall_out tied 0, no FSM or multiplier logic.

Test Plan:
- ADD with val_rn=0x7FFFFFFF, val_rm=1, immd=0, shift 0, S=1 -> alu_res_out=0x80000000 next cycle; status_out N=1 Z=0 C=0 V=1; status_w_en_out=1.
- MOV imm8=0xFF with rotate=4 (ROR 8) -> alu_res_out=0xFF000000.
- fwd_sel_src1=1, mem_fwd_value=10, SUB val2=10, S=1 -> result 0, Z=1, C=1.
- MUL 6*7, MUL_LATENCY=3 -> stall_out high for 2 cycles with valid_out=0 on those edges; then alu_res_out=42 with valid_out=1 and a single status_w_en_out pulse.
- freeze asserted mid-MUL for 2 cycles -> outputs and cnt hold; result appears 2 cycles later; flush mid-MUL -> valid_out=0, stall_out=0, FSM IDLE next cycle.
- Branch: pc_in=0x100, signed_immd_24=0xFFFFFE -> branch_address_out=0xF8, branch_taken_out=1; rst asserted -> all registered outputs 0 after the edge.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// ARM execute stage merged with its EX/MEM register: forwarding, shifter operand, ALU + NZCV,
// branch target. Define EX_MUL_EN to build the multi-cycle multiplier and its stall handshake.
module ex_stage_pipe #(
  parameter int REG_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MUL_LATENCY    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_in,
  input  logic [ADDR_WIDTH-1:0]     pc_in,
  input  logic                      wb_en_in,
  input  logic                      mem_r_en_in,
  input  logic                      mem_w_en_in,
  input  logic                      s_in,
  input  logic                      b_in,
  input  logic                      immd,
  input  logic [3:0]                exe_cmd,
  input  logic [REG_WIDTH-1:0]      val_rn,
  input  logic [REG_WIDTH-1:0]      val_rm_in,
  input  logic [REG_ADDR_WIDTH-1:0] dest_in,
  input  logic [23:0]               signed_immd_24,
  input  logic [11:0]               shift_operand,
  input  logic [3:0]                status_reg_in,
  input  logic [1:0]                fwd_sel_src1,
  input  logic [1:0]                fwd_sel_src2,
  input  logic [REG_WIDTH-1:0]      mem_fwd_value,
  input  logic [REG_WIDTH-1:0]      wb_fwd_value,
  input  logic                      freeze,
  input  logic                      flush,
  output logic                      stall_out,
  output logic                      valid_out,
  output logic                      wb_en_out,
  output logic                      mem_r_en_out,
  output logic                      mem_w_en_out,
  output logic [REG_WIDTH-1:0]      alu_res_out,
  output logic [REG_WIDTH-1:0]      val_rm_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_out,
  output logic                      status_w_en_out,
  output logic [3:0]                status_out,
  output logic                      branch_taken_out,
  output logic [ADDR_WIDTH-1:0]     branch_address_out,
  output logic                      wb_en_hazard_out,
  output logic [REG_ADDR_WIDTH-1:0] dest_hazard_out
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int MSB   = REG_WIDTH - 1;
  localparam int OFF_W = (ADDR_WIDTH > 26) ? ADDR_WIDTH : 26;

  // Rotation wraps modulo the datapath width so narrow builds stay well-defined.
  function automatic logic [REG_WIDTH-1:0] rotr(input logic [REG_WIDTH-1:0] x,
                                                input logic [5:0] amt);
    logic [2*REG_WIDTH-1:0] dbl;
    dbl = {x, x} >> (amt % REG_WIDTH);
    return dbl[REG_WIDTH-1:0];
  endfunction

  logic [REG_WIDTH-1:0] src1;
  logic [REG_WIDTH-1:0] rm_fwd;
  logic [REG_WIDTH-1:0] shifted;
  logic [REG_WIDTH-1:0] val2;
  logic [REG_WIDTH-1:0] add_b;
  logic                 add_cin;
  logic [REG_WIDTH:0]   sum;
  logic [REG_WIDTH-1:0] alu_res;
  logic                 arith_op;
  logic                 known_op;
  logic [4:0]           shift_amt;
  logic [1:0]           shift_type;

  assign shift_amt  = shift_operand[11:7];
  assign shift_type = shift_operand[6:5];

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    src1 = val_rn;
    case (fwd_sel_src1)
      2'd1:    src1 = mem_fwd_value;
      2'd2:    src1 = wb_fwd_value;
      default: src1 = val_rn;
    endcase
    rm_fwd = val_rm_in;
    case (fwd_sel_src2)
      2'd1:    rm_fwd = mem_fwd_value;
      2'd2:    rm_fwd = wb_fwd_value;
      default: rm_fwd = val_rm_in;
    endcase
  end

  always_comb begin
    shifted = rm_fwd;
    case (shift_type)
      2'b00:   shifted = rm_fwd << shift_amt;
      2'b01:   shifted = rm_fwd >> shift_amt;
      2'b10:   shifted = $signed(rm_fwd) >>> shift_amt;
      default: shifted = rotr(rm_fwd, {1'b0, shift_amt});
    endcase

    // Loads/stores use the raw 12-bit offset regardless of the immd bit.
    if (mem_r_en_in || mem_w_en_in)
      val2 = REG_WIDTH'(shift_operand);
    else if (immd)
      val2 = rotr(REG_WIDTH'(shift_operand[7:0]), {1'b0, shift_operand[11:8], 1'b0});
    else
      val2 = shifted;
  end

`ifdef EX_MUL_EN
  localparam logic [3:0] CMD_MUL   = 4'b1010;
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [3:0] CNT_INIT  = MUL_MULTI ? 4'(MUL_LATENCY - 2) : 4'd0;

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t           state;
  logic [3:0]           cnt;
  logic                 mul_issue;
  logic [REG_WIDTH-1:0] mul_now;
  logic [REG_WIDTH-1:0] mul_hold;
  logic [REG_WIDTH-1:0] mul_res;

  assign mul_now   = src1 * val2;
  assign mul_issue = valid_in && (exe_cmd == CMD_MUL) && MUL_MULTI && (state == IDLE);
  assign mul_res   = (state == BUSY) ? mul_hold : mul_now;
  assign stall_out = mul_issue || ((state == BUSY) && (cnt != 4'd0));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else if (!freeze) begin
      case (state)
        IDLE: if (mul_issue) begin
          state <= BUSY;
          cnt   <= CNT_INIT;
        end
        BUSY: if (cnt == 4'd0) state <= IDLE;
              else             cnt   <= cnt - 4'd1;
      endcase
    end
  end

  // NOTE: pure data register with no reset; it is only read in BUSY, which always follows a capture.
  always_ff @(posedge clk) begin
    if (mul_issue && !freeze && !flush) mul_hold <= mul_now;
  end
`else
  assign stall_out = 1'b0;
`endif

  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    case (exe_cmd)
      CMD_ADC: add_cin = status_reg_in[1];
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;             end
      CMD_SBC: begin add_b = ~val2; add_cin = status_reg_in[1]; end
      default: ;
    endcase
    // Subtraction as a + ~b + cin makes the carry out the inverse of the borrow.
    sum = {1'b0, src1} + {1'b0, add_b} + {{REG_WIDTH{1'b0}}, add_cin};

    alu_res  = '0;
    arith_op = 1'b0;
    known_op = 1'b1;
    case (exe_cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        alu_res  = sum[REG_WIDTH-1:0];
        arith_op = 1'b1;
      end
      CMD_AND: alu_res = src1 & val2;
      CMD_ORR: alu_res = src1 | val2;
      CMD_EOR: alu_res = src1 ^ val2;
`ifdef EX_MUL_EN
      CMD_MUL: alu_res = mul_res;
`endif
      default: known_op = 1'b0;
    endcase

    status_out = status_reg_in;
    if (known_op) begin
      status_out[3] = alu_res[MSB];
      status_out[2] = (alu_res == '0);
      if (arith_op) begin
        status_out[1] = sum[REG_WIDTH];
        status_out[0] = (src1[MSB] == add_b[MSB]) && (alu_res[MSB] != src1[MSB]);
      end
    end
  end

  assign status_w_en_out  = valid_in & s_in & ~stall_out & ~freeze & ~flush;
  assign branch_taken_out = valid_in & b_in & ~stall_out;
  assign wb_en_hazard_out = wb_en_in;
  assign dest_hazard_out  = dest_in;

  logic signed [25:0] br_off;
  logic [OFF_W-1:0]   br_off_ext;
  assign br_off             = {signed_immd_24, 2'b00};
  assign br_off_ext         = OFF_W'(br_off);
  assign branch_address_out = pc_in + br_off_ext[ADDR_WIDTH-1:0];

  // A stall inserts a bubble: enables drop while data and destination keep their last values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_out    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      alu_res_out  <= '0;
      val_rm_out   <= '0;
      dest_out     <= '0;
    end else if (!freeze) begin
      if (stall_out) begin
        valid_out    <= 1'b0;
        wb_en_out    <= 1'b0;
        mem_r_en_out <= 1'b0;
        mem_w_en_out <= 1'b0;
      end else begin
        valid_out    <= valid_in;
        wb_en_out    <= wb_en_in & valid_in;
        mem_r_en_out <= mem_r_en_in & valid_in;
        mem_w_en_out <= mem_w_en_in & valid_in;
        alu_res_out  <= alu_res;
        val_rm_out   <= rm_fwd;
        dest_out     <= dest_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe: table-driven ALU/shifter/branch vectors plus
// hand-written freeze, flush, reset and (with EX_MUL_EN) multiply sequences.
module tb_ex_stage_pipe;
  localparam int RW  = 32;
  localparam int AW  = 32;
  localparam int RAW = 4;
  localparam int ML  = 3;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [RW-1:0] MEM_FWD = 32'd10;
  localparam logic [RW-1:0] WB_FWD  = 32'h0000_0F00;

  logic clk = 1'b0;
  logic rst;
  logic valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, s_in, b_in, immd;
  logic [AW-1:0]  pc_in;
  logic [3:0]     exe_cmd;
  logic [RW-1:0]  val_rn, val_rm_in, mem_fwd_value, wb_fwd_value;
  logic [RAW-1:0] dest_in;
  logic [23:0]    signed_immd_24;
  logic [11:0]    shift_operand;
  logic [3:0]     status_reg_in;
  logic [1:0]     fwd_sel_src1, fwd_sel_src2;
  logic           freeze, flush;
  logic           stall_out, valid_out, wb_en_out, mem_r_en_out, mem_w_en_out;
  logic [RW-1:0]  alu_res_out, val_rm_out;
  logic [RAW-1:0] dest_out, dest_hazard_out;
  logic           status_w_en_out, branch_taken_out, wb_en_hazard_out;
  logic [3:0]     status_out;
  logic [AW-1:0]  branch_address_out;

  always #5 clk = ~clk;

  ex_stage_pipe #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(RAW), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .b_in(b_in), .immd(immd), .exe_cmd(exe_cmd),
    .val_rn(val_rn), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .signed_immd_24(signed_immd_24), .shift_operand(shift_operand),
    .status_reg_in(status_reg_in), .fwd_sel_src1(fwd_sel_src1), .fwd_sel_src2(fwd_sel_src2),
    .mem_fwd_value(mem_fwd_value), .wb_fwd_value(wb_fwd_value),
    .freeze(freeze), .flush(flush), .stall_out(stall_out),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out), .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .status_w_en_out(status_w_en_out), .status_out(status_out),
    .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
    .wb_en_hazard_out(wb_en_hazard_out), .dest_hazard_out(dest_hazard_out)
  );

  // Field order: valid cmd s immd mr mw wb b rn rm f1 f2 sh st dest pc off exp_res exp_st exp_ba
  typedef struct {
    logic valid; logic [3:0] cmd; logic s, immd, mr, mw, wb, b;
    logic [RW-1:0] rn, rm; logic [1:0] f1, f2; logic [11:0] sh; logic [3:0] st;
    logic [RAW-1:0] dest; logic [AW-1:0] pc; logic [23:0] off;
    logic [RW-1:0] exp_res; logic [3:0] exp_st; logic [AW-1:0] exp_ba;
  } vec_t;

  typedef struct {
    logic valid, wb, mr, mw;
    logic [RW-1:0] res, rm;
    logic [RAW-1:0] dest;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t last;
  exp_t zero_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] fwd_rm(input vec_t v);
    case (v.f2)
      2'd1:    return MEM_FWD;
      2'd2:    return WB_FWD;
      default: return v.rm;
    endcase
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.valid = v.valid;
    e.wb    = v.wb & v.valid;
    e.mr    = v.mr & v.valid;
    e.mw    = v.mw & v.valid;
    e.res   = v.exp_res;
    e.rm    = fwd_rm(v);
    e.dest  = v.dest;
    return e;
  endfunction

  function automatic exp_t bubble_of(input exp_t p);
    exp_t e;
    e = p;
    e.valid = 1'b0; e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    return e;
  endfunction

  task automatic push(input exp_t e);
    sb.push_back(e);
    last = e;
  endtask

  task automatic tick_check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, no expected value", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid_out"},    valid_out,    e.valid);
      check({tag, ".wb_en_out"},    wb_en_out,    e.wb);
      check({tag, ".mem_r_en_out"}, mem_r_en_out, e.mr);
      check({tag, ".mem_w_en_out"}, mem_w_en_out, e.mw);
      check({tag, ".alu_res_out"},  alu_res_out,  e.res);
      check({tag, ".val_rm_out"},   val_rm_out,   e.rm);
      check({tag, ".dest_out"},     dest_out,     e.dest);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_in = v.valid; exe_cmd = v.cmd; s_in = v.s; immd = v.immd;
    mem_r_en_in = v.mr; mem_w_en_in = v.mw; wb_en_in = v.wb; b_in = v.b;
    val_rn = v.rn; val_rm_in = v.rm; fwd_sel_src1 = v.f1; fwd_sel_src2 = v.f2;
    shift_operand = v.sh; status_reg_in = v.st; dest_in = v.dest;
    pc_in = v.pc; signed_immd_24 = v.off;
  endtask

  task automatic clear_inputs();
    valid_in = 0; exe_cmd = 0; s_in = 0; immd = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    wb_en_in = 0; b_in = 0; val_rn = 0; val_rm_in = 0; fwd_sel_src1 = 0; fwd_sel_src2 = 0;
    shift_operand = 0; status_reg_in = 0; dest_in = 0; pc_in = 0; signed_immd_24 = 0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check({tag, ".stall_out"},          stall_out,          1'b0);
    check({tag, ".status_out"},         status_out,         v.exp_st);
    check({tag, ".status_w_en_out"},    status_w_en_out,    v.valid & v.s);
    check({tag, ".branch_taken_out"},   branch_taken_out,   v.valid & v.b);
    check({tag, ".branch_address_out"}, branch_address_out, v.exp_ba);
    check({tag, ".wb_en_hazard_out"},   wb_en_hazard_out,   v.wb);
    check({tag, ".dest_hazard_out"},    dest_hazard_out,    v.dest);
    push(exp_of(v));
    tick_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t m;
    zero_e = '{default: '0};
    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    mem_fwd_value = MEM_FWD; wb_fwd_value = WB_FWD;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset.valid_out", valid_out, 1'b0);
    check("reset.wb_en_out", wb_en_out, 1'b0);
    check("reset.mem_r_en_out", mem_r_en_out, 1'b0);
    check("reset.mem_w_en_out", mem_w_en_out, 1'b0);
    check("reset.alu_res_out", alu_res_out, 32'h0);
    check("reset.val_rm_out", val_rm_out, 32'h0);
    check("reset.dest_out", dest_out, 4'h0);
    check("reset.stall_out", stall_out, 1'b0);
    rst = 1'b0;
    last = zero_e;

    vecs.push_back(vec_t'{T,4'b0010,T,F,F,F,T,F, 32'h7FFF_FFFF,32'h1, 2'd0,2'd0, 12'h000,4'b0000, 4'd1, 32'h0,24'h0, 32'h8000_0000,4'b1001,32'h0});
    vecs.push_back(vec_t'{T,4'b0001,F,T,F,F,T,F, 32'h0,32'h0, 2'd0,2'd0, 12'h4FF,4'b0110, 4'd2, 32'h0,24'h0, 32'hFF00_0000,4'b1010,32'h0});
    vecs.push_back(vec_t'{T,4'b0100,T,T,F,F,T,F, 32'h5,32'h0, 2'd1,2'd0, 12'h00A,4'b0000, 4'd3, 32'h0,24'h0, 32'h0,4'b0110,32'h0});
    vecs.push_back(vec_t'{T,4'b0001,T,F,F,F,T,F, 32'h0,32'h8000_0000, 2'd0,2'd0, 12'h220,4'b0000, 4'd4, 32'h0,24'h0, 32'h0800_0000,4'b0000,32'h0});
    vecs.push_back(vec_t'{T,4'b0001,T,F,F,F,T,F, 32'h0,32'h8000_0000, 2'd0,2'd0, 12'h240,4'b0000, 4'd5, 32'h0,24'h0, 32'hF800_0000,4'b1000,32'h0});
    vecs.push_back(vec_t'{T,4'b0111,T,F,F,F,T,F, 32'h1,32'hF, 2'd0,2'd0, 12'h260,4'b0011, 4'd6, 32'h0,24'h0, 32'hF000_0001,4'b1011,32'h0});
    vecs.push_back(vec_t'{T,4'b0110,T,F,F,F,T,F, 32'hFFFF_FFFF,32'h1, 2'd0,2'd0, 12'hF80,4'b0000, 4'd7, 32'h0,24'h0, 32'h8000_0000,4'b1000,32'h0});
    vecs.push_back(vec_t'{T,4'b1001,T,T,F,F,T,F, 32'h0,32'h0, 2'd0,2'd0, 12'h000,4'b0000, 4'd8, 32'h0,24'h0, 32'hFFFF_FFFF,4'b1000,32'h0});
    vecs.push_back(vec_t'{T,4'b1000,T,F,F,F,T,F, 32'hFF00_FF00,32'h0FF0_0FF0, 2'd0,2'd0, 12'h000,4'b0000, 4'd9, 32'h0,24'h0, 32'hF0F0_F0F0,4'b1000,32'h0});
    vecs.push_back(vec_t'{T,4'b0011,T,F,F,F,T,F, 32'hFFFF_FFFF,32'h0, 2'd0,2'd0, 12'h000,4'b0010, 4'd10, 32'h0,24'h0, 32'h0,4'b0110,32'h0});
    vecs.push_back(vec_t'{T,4'b0101,T,T,F,F,T,F, 32'h5,32'h0, 2'd0,2'd0, 12'h003,4'b0000, 4'd11, 32'h0,24'h0, 32'h1,4'b0010,32'h0});
    vecs.push_back(vec_t'{T,4'b0100,T,T,F,F,T,F, 32'h3,32'h0, 2'd0,2'd0, 12'h005,4'b0000, 4'd12, 32'h0,24'h0, 32'hFFFF_FFFE,4'b1000,32'h0});
    vecs.push_back(vec_t'{T,4'b0010,F,F,T,F,T,F, 32'h1000,32'h55, 2'd0,2'd2, 12'hFFF,4'b0000, 4'd13, 32'h0,24'h0, 32'h1FFF,4'b0000,32'h0});
    vecs.push_back(vec_t'{T,4'b0010,F,F,F,T,F,F, 32'h20,32'hDEAD_BEEF, 2'd0,2'd0, 12'h004,4'b1111, 4'd14, 32'h0,24'h0, 32'h24,4'b0000,32'h0});
    vecs.push_back(vec_t'{T,4'b0000,T,F,F,F,T,F, 32'h1,32'h1, 2'd0,2'd0, 12'h000,4'b0101, 4'd15, 32'h1000,24'h7F_FFFF, 32'h0,4'b0101,32'h0200_0FFC});
`ifndef EX_MUL_EN
    vecs.push_back(vec_t'{T,4'b1010,T,F,F,F,T,F, 32'h6,32'h7, 2'd0,2'd0, 12'h000,4'b1100, 4'd1, 32'h0,24'h0, 32'h0,4'b1100,32'h0});
`endif
    vecs.push_back(vec_t'{F,4'b0010,T,F,T,F,T,F, 32'h2,32'h3, 2'd0,2'd0, 12'h000,4'b0000, 4'd2, 32'h0,24'h0, 32'h2,4'b0000,32'h0});
    vecs.push_back(vec_t'{T,4'b0000,F,F,F,F,F,T, 32'h0,32'h0, 2'd0,2'd0, 12'h000,4'b0000, 4'd3, 32'h100,24'hFF_FFFE, 32'h0,4'b0000,32'h0F8});
    vecs.push_back(vec_t'{T,4'b0000,F,F,F,F,F,T, 32'h0,32'h0, 2'd0,2'd0, 12'h000,4'b0000, 4'd4, 32'hFFFF_FFFC,24'h00_0001, 32'h0,4'b0000,32'h0});

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Freeze holds the register and suppresses the flag write.
    apply(vecs[0], "pre_freeze");
    drive(vecs[2]);
    freeze = 1'b1;
    @(negedge clk);
    check("freeze.status_w_en_out", status_w_en_out, 1'b0);
    push(last);
    tick_check("freeze");
    freeze = 1'b0;

    // Flush squashes the instruction.
    drive(vecs[5]);
    flush = 1'b1;
    @(negedge clk);
    check("flush.status_w_en_out", status_w_en_out, 1'b0);
    push(zero_e);
    tick_check("flush");
    flush = 1'b0;

`ifdef EX_MUL_EN
    m = vec_t'{T,4'b1010,T,F,F,F,T,F, 32'h6,32'h7, 2'd0,2'd0, 12'h000,4'b0011, 4'd5, 32'h0,24'h0, 32'd42,4'b0011,32'h0};
    drive(m);
    for (int i = 0; i < ML - 1; i++) begin
      @(negedge clk);
      check("mul.stall_out", stall_out, 1'b1);
      check("mul.status_w_en_out", status_w_en_out, 1'b0);
      push(bubble_of(last));
      tick_check("mul.bubble");
    end
    @(negedge clk);
    check("mul.last.stall_out", stall_out, 1'b0);
    check("mul.last.status_w_en_out", status_w_en_out, 1'b1);
    check("mul.last.status_out", status_out, 4'b0011);
    push(exp_of(m));
    tick_check("mul.done");

    m = vec_t'{T,4'b1010,T,F,F,F,T,F, 32'h3,32'h5, 2'd0,2'd0, 12'h000,4'b0000, 4'd6, 32'h0,24'h0, 32'd15,4'b0000,32'h0};
    drive(m);
    @(negedge clk);
    check("mulfrz.issue.stall_out", stall_out, 1'b1);
    push(bubble_of(last));
    tick_check("mulfrz.bubble");
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mulfrz.hold.stall_out", stall_out, 1'b1);
      check("mulfrz.hold.status_w_en_out", status_w_en_out, 1'b0);
      push(last);
      tick_check("mulfrz.hold");
    end
    freeze = 1'b0;
    for (int i = 0; i < ML - 2; i++) begin
      @(negedge clk);
      check("mulfrz.resume.stall_out", stall_out, 1'b1);
      push(bubble_of(last));
      tick_check("mulfrz.resume");
    end
    @(negedge clk);
    check("mulfrz.last.stall_out", stall_out, 1'b0);
    check("mulfrz.last.status_w_en_out", status_w_en_out, 1'b1);
    push(exp_of(m));
    tick_check("mulfrz.done");

    m = vec_t'{T,4'b1010,T,F,F,F,T,F, 32'h2,32'h9, 2'd0,2'd0, 12'h000,4'b0000, 4'd7, 32'h0,24'h0, 32'd18,4'b0000,32'h0};
    drive(m);
    @(negedge clk);
    push(bubble_of(last));
    tick_check("mulflush.bubble");
    flush = 1'b1;
    @(negedge clk);
    check("mulflush.status_w_en_out", status_w_en_out, 1'b0);
    push(zero_e);
    tick_check("mulflush");
    flush = 1'b0;
    clear_inputs();
    @(negedge clk);
    check("mulflush.idle.stall_out", stall_out, 1'b0);
    push(zero_e);
    tick_check("mulflush.idle");
`endif

    // Synchronous reset with a live instruction on the inputs.
    apply(vecs[0], "pre_reset");
    drive(vecs[3]);
    rst = 1'b1;
    @(negedge clk);
    push(zero_e);
    tick_check("midreset");
    rst = 1'b0;
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
